// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   seq_tx_state_e         : transmitter FSM states
//   SEQ_TX_PAT_W           : native pattern length
//   SEQ_TX_DEFAULT_PATTERN : pattern sent when the default is selected; the sequence
//                            detector bench recognises the same value
package seq_tx_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap,
      StDone
   } seq_tx_state_e;

   localparam int unsigned SEQ_TX_PAT_W = 12;
   localparam logic [SEQ_TX_PAT_W-1:0] SEQ_TX_DEFAULT_PATTERN = 12'b1110_1101_1011;

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in serial-out shift register, MSB first.
// The register shifts in zeros, so after W shifts it reads all-zero.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : synchronous clear (priority over load/shift)
//   load, din  : parallel load (priority over shift)
//   shift      : shift left by one, zero fill
//   msb        : current most significant bit (registered)
module seq_piso_shreg #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= din;
      end else if (shift) begin
         data_q <= {data_q[W-2:0], 1'b0};
      end
   end

   assign msb = data_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, one bit per clock,
// optionally repeating it with an idle gap between frames.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start_i         : request, accepted in IDLE or DONE
//   use_default_i   : at accept, 1 sends DEFAULT_PATTERN, 0 sends pattern_i
//   pattern_i       : pattern to send, bit PAT_W-1 first
//   repeat_i        : number of frames (0 treated as 1)
//   gap_i           : idle cycles between frames (0 = back-to-back)
//   abort_i         : cancel transmission (busy or DONE), no done pulse
//   x_o, valid_o    : serial data and its qualifier
//   frame_start_o   : first bit of each frame
//   busy_o, done_o  : transmission in progress / one-cycle completion pulse
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int unsigned       PAT_W           = 12,
   parameter logic [PAT_W-1:0]  DEFAULT_PATTERN = PAT_W'(SEQ_TX_DEFAULT_PATTERN),
   parameter int unsigned       CNT_W           = 8,
   parameter int unsigned       GAP_W           = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             use_default_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] repeat_i,
   input  logic [GAP_W-1:0] gap_i,
   input  logic             abort_i,
   output logic             x_o,
   output logic             valid_o,
   output logic             frame_start_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

   seq_tx_state_e    state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic             valid_q, valid_d;
   logic             fs_q, fs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sh_clear, sh_load, sh_shift;
   logic [PAT_W-1:0] sh_din;
   logic             accept;
   logic [PAT_W-1:0] sel_pat;

   assign sel_pat = use_default_i ? DEFAULT_PATTERN : pattern_i;

   // x_o is the shift register MSB. The register drains to zero after the last bit, so
   // x_o is naturally 0 in GAP, DONE and IDLE without any extra gating.
   seq_piso_shreg #(
      .W (PAT_W)
   ) u_shreg (
      .clk   (clk),
      .reset (reset),
      .clear (sh_clear),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (sh_din),
      .msb   (x_o)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      frames_d  = frames_q;
      gap_cfg_d = gap_cfg_q;
      gap_cnt_d = gap_cnt_q;
      pat_d     = pat_q;
      valid_d   = 1'b0;
      fs_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      sh_clear  = 1'b0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      sh_din    = pat_q;
      accept    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) accept = 1'b1;
         end
         StDone: begin
            if (abort_i) begin
               state_d  = StIdle;
               sh_clear = 1'b1;
            end else if (start_i) begin
               accept = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            if (abort_i) begin
               state_d  = StIdle;
               sh_clear = 1'b1;
            end else if (bit_cnt_q != LAST_BIT) begin
               sh_shift  = 1'b1;
               bit_cnt_d = bit_cnt_q + BW'(1);
               valid_d   = 1'b1;
               busy_d    = 1'b1;
            end else if (frames_q > CNT_W'(1)) begin
               frames_d = frames_q - CNT_W'(1);
               busy_d   = 1'b1;
               if (gap_cfg_q != '0) begin
                  state_d   = StGap;
                  gap_cnt_d = gap_cfg_q;
                  sh_shift  = 1'b1;
               end else begin
                  // Back-to-back: reload the captured pattern with no bubble.
                  sh_load   = 1'b1;
                  bit_cnt_d = '0;
                  valid_d   = 1'b1;
                  fs_d      = 1'b1;
               end
            end else begin
               state_d  = StDone;
               done_d   = 1'b1;
               sh_shift = 1'b1;
            end
         end
         StGap: begin
            if (abort_i) begin
               state_d  = StIdle;
               sh_clear = 1'b1;
            end else begin
               busy_d = 1'b1;
               // gap_cnt runs gap..1, so the gap lasts exactly gap cycles.
               if (gap_cnt_q == GAP_W'(1)) begin
                  state_d   = StShift;
                  sh_load   = 1'b1;
                  bit_cnt_d = '0;
                  valid_d   = 1'b1;
                  fs_d      = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
         end
         default: begin
            state_d  = StIdle;
            sh_clear = 1'b1;
         end
      endcase

      if (accept) begin
         state_d   = StShift;
         sh_load   = 1'b1;
         sh_din    = sel_pat;
         pat_d     = sel_pat;
         frames_d  = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
         gap_cfg_d = gap_i;
         bit_cnt_d = '0;
         valid_d   = 1'b1;
         fs_d      = 1'b1;
         busy_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         frames_q  <= '0;
         gap_cfg_q <= '0;
         gap_cnt_q <= '0;
         pat_q     <= '0;
         valid_q   <= 1'b0;
         fs_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         frames_q  <= frames_d;
         gap_cfg_q <= gap_cfg_d;
         gap_cnt_q <= gap_cnt_d;
         pat_q     <= pat_d;
         valid_q   <= valid_d;
         fs_q      <= fs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign valid_o       = valid_q;
   assign frame_start_o = fs_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. Expected per-cycle traces
// {x, valid, frame_start, busy, done} come from a frame-level model.
module tb_seq_pattern_tx;

   localparam int PW = 12;
   localparam logic [PW-1:0] DEF_PAT = 12'b1110_1101_1011;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_i;
   logic          use_default_i;
   logic [PW-1:0] pattern_i;
   logic [7:0]    repeat_i;
   logic [3:0]    gap_i;
   logic          abort_i;
   logic          x_o, valid_o, frame_start_o, busy_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef logic [4:0] trace_t[$];

   seq_pattern_tx dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .use_default_i (use_default_i),
      .pattern_i     (pattern_i),
      .repeat_i      (repeat_i),
      .gap_i         (gap_i),
      .abort_i       (abort_i),
      .x_o           (x_o),
      .valid_o       (valid_o),
      .frame_start_o (frame_start_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   // Frame-level model: frames of PW bits, gap idle-busy cycles between frames, then one
   // done cycle. Trace starts with the cycle after the accept edge.
   function automatic trace_t model(input logic [PW-1:0] pat, input int rep, input int gap);
      trace_t q;
      int frames = (rep == 0) ? 1 : rep;
      for (int f = 0; f < frames; f++) begin
         for (int b = 0; b < PW; b++) q.push_back({pat[PW-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
         if (f < frames - 1)
            for (int g = 0; g < gap; g++) q.push_back(5'b00010);
      end
      q.push_back(5'b00001);
      return q;
   endfunction

   function automatic logic [4:0] obs();
      return {x_o, valid_o, frame_start_o, busy_o, done_o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic udef, input logic [PW-1:0] pat, input logic [7:0] rep,
                         input logic [3:0] gap);
      start_i       = 1'b1;
      use_default_i = udef;
      pattern_i     = pat;
      repeat_i      = rep;
      gap_i         = gap;
   endtask

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b1; use_default_i = 1'b1; abort_i = 1'b0;
      pattern_i = '0; repeat_i = 8'd1; gap_i = '0;
      step();
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 00000", obs());
      end
      start_i = 1'b0;
      reset   = 1'b0;
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got %b expected 00000", obs());
      end
   endtask

   task automatic test_default();
      trace_t exp;
      int busy_n = 0;
      launch(1'b1, PW'($urandom), 8'd1, 4'($urandom));
      exp = model(DEF_PAT, 1, 0);
      for (int i = 0; i < exp.size(); i++) begin
         step();
         start_i = 1'b0;
         busy_n += int'(busy_o);
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++; $display("FAIL default cyc %0d: got %b expected %b", i, obs(), exp[i]);
         end
      end
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL default_idle: got %b expected 00000", obs());
      end
      n_checks++;
      if (busy_n != 12) begin
         n_fail++; $display("FAIL default_busy_len: got %0d expected 12", busy_n);
      end
   endtask

   // Fixed and random frame configurations; junk start/input changes while busy.
   task automatic test_patterns();
      for (int k = 0; k < 8; k++) begin
         trace_t exp;
         logic [PW-1:0] pat;
         int rep, gap, frames, busy_n;
         busy_n = 0;
         if (k == 0) begin
            pat = 12'hA5C; rep = 3; gap = 2;
         end else if (k == 1) begin
            pat = PW'($urandom); rep = 2; gap = 0;
         end else begin
            pat = PW'($urandom); rep = $urandom_range(0, 4); gap = $urandom_range(0, 3);
         end
         frames = (rep == 0) ? 1 : rep;
         launch(1'b0, pat, 8'(rep), 4'(gap));
         abort_i = 1'b0;
         exp = model(pat, rep, gap);
         for (int i = 0; i < exp.size(); i++) begin
            step();
            if (i < exp.size() - 1) begin
               start_i = 1'($urandom); pattern_i = PW'($urandom);
               use_default_i = 1'($urandom); repeat_i = 8'($urandom); gap_i = 4'($urandom);
            end else begin
               start_i = 1'b0;
            end
            busy_n += int'(busy_o);
            n_checks++;
            if (obs() !== exp[i]) begin
               n_fail++;
               $display("FAIL pattern k%0d cyc %0d: got %b expected %b", k, i, obs(), exp[i]);
            end
         end
         n_checks++;
         if (busy_n != frames * PW + (frames - 1) * gap) begin
            n_fail++; $display("FAIL busy_len k%0d: got %0d expected %0d", k, busy_n,
                               frames * PW + (frames - 1) * gap);
         end
         step();
         n_checks++;
         if (obs() !== 5'b0) begin
            n_fail++; $display("FAIL pattern_idle k%0d: got %b expected 00000", k, obs());
         end
      end
   endtask

   task automatic test_repeat_zero();
      trace_t exp;
      logic [PW-1:0] pat = PW'($urandom);
      launch(1'b0, pat, 8'd0, 4'($urandom_range(1, 15)));
      exp = model(pat, 1, 0);
      for (int i = 0; i < exp.size(); i++) begin
         step();
         start_i = 1'b0;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++; $display("FAIL repeat0 cyc %0d: got %b expected %b", i, obs(), exp[i]);
         end
      end
      step();
   endtask

   task automatic test_abort();
      trace_t exp;
      logic [PW-1:0] pat = PW'($urandom);
      launch(1'b0, pat, 8'd2, 4'd1);
      exp = model(pat, 2, 1);
      for (int i = 0; i <= 5; i++) begin
         step();
         start_i = 1'($urandom);
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++; $display("FAIL abort_pre cyc %0d: got %b expected %b", i, obs(), exp[i]);
         end
      end
      abort_i = 1'b1;
      start_i = 1'b1;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL abort_next: got %b expected 00000", obs());
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs() !== 5'b0) begin
            n_fail++; $display("FAIL abort_quiet cyc %0d: got %b expected 00000", i, obs());
         end
      end
   endtask

   task automatic test_back_to_back();
      trace_t exp, two;
      logic [PW-1:0] pat = PW'($urandom);
      launch(1'b0, pat, 8'd1, 4'd0);
      exp = model(pat, 1, 0);
      two = exp;
      foreach (exp[i]) two.push_back(exp[i]);
      for (int i = 0; i < two.size(); i++) begin
         step();
         if (i == two.size() - 1) start_i = 1'b0;
         n_checks++;
         if (obs() !== two[i]) begin
            n_fail++; $display("FAIL b2b cyc %0d: got %b expected %b", i, obs(), two[i]);
         end
      end
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL b2b_idle: got %b expected 00000", obs());
      end
   endtask

   task automatic test_reset_mid_gap();
      trace_t exp;
      logic [PW-1:0] pat = PW'($urandom);
      launch(1'b0, pat, 8'd2, 4'd5);
      exp = model(pat, 2, 5);
      for (int i = 0; i <= 13; i++) begin
         step();
         start_i = 1'b0;
         n_checks++;
         if (obs() !== exp[i]) begin
            n_fail++; $display("FAIL gap_pre cyc %0d: got %b expected %b", i, obs(), exp[i]);
         end
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL reset_mid_gap: got %b expected 00000", obs());
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (obs() !== 5'b0) begin
         n_fail++; $display("FAIL reset_mid_gap_idle: got %b expected 00000", obs());
      end
   endtask

   // Behavioural 12-bit detector on valid bits: one hit per transmitted default frame.
   task automatic test_loopback();
      for (int k = 0; k < 2; k++) begin
         trace_t exp;
         logic [PW-1:0] window = '0;
         int dets = 0;
         int gap = (k == 0) ? 0 : 2;
         launch(1'b1, PW'($urandom), 8'd3, 4'(gap));
         exp = model(DEF_PAT, 3, gap);
         for (int i = 0; i < exp.size(); i++) begin
            step();
            start_i = 1'b0;
            if (valid_o === 1'b1) begin
               window = {window[PW-2:0], x_o};
               if (window == DEF_PAT) dets++;
            end
            n_checks++;
            if (obs() !== exp[i]) begin
               n_fail++;
               $display("FAIL loop k%0d cyc %0d: got %b expected %b", k, i, obs(), exp[i]);
            end
         end
         n_checks++;
         if (dets != 3) begin
            n_fail++; $display("FAIL loop_dets k%0d: got %0d expected 3", k, dets);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_patterns();
      test_repeat_zero();
      test_abort();
      test_back_to_back();
      test_reset_mid_gap();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
